// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES decryption datapath.
package aes_dec_pkg;

  localparam int unsigned STATE_W = 128;
  localparam int unsigned COL_W   = 32;
  localparam int unsigned BYTE_W  = 8;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [COL_W-1:0]   col_t;
  typedef logic [BYTE_W-1:0]  byte_t;

  typedef enum logic [1:0] {IDLE, MIX, DONE} fsm_t;

  // InvMixColumns matrix coefficients (first row order: 0e 0b 0d 09)
  localparam byte_t COEF_E = 8'h0e;
  localparam byte_t COEF_B = 8'h0b;
  localparam byte_t COEF_D = 8'h0d;
  localparam byte_t COEF_9 = 8'h09;

  // Multiply by 02 modulo x^8 + x^4 + x^3 + x + 1
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_word.sv
// Combinational InvMixColumns transform of one 32-bit column (a0 = MSB byte).
module inv_mix_word
  import aes_dec_pkg::*;
(
  input  col_t col,
  output col_t mixed
);

  // Constant multiply from an xtime chain; coefficients only use bits 0..3.
  function automatic byte_t mul(input byte_t b, input byte_t coef);
    byte_t b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return (coef[0] ? b  : 8'h00) ^ (coef[1] ? b2 : 8'h00) ^
           (coef[2] ? b4 : 8'h00) ^ (coef[3] ? b8 : 8'h00);
  endfunction

  byte_t a0, a1, a2, a3;
  byte_t r0, r1, r2, r3;

  assign a0 = col[31:24];
  assign a1 = col[23:16];
  assign a2 = col[15:8];
  assign a3 = col[7:0];

  assign r0 = mul(a0, COEF_E) ^ mul(a1, COEF_B) ^ mul(a2, COEF_D) ^ mul(a3, COEF_9);
  assign r1 = mul(a0, COEF_9) ^ mul(a1, COEF_E) ^ mul(a2, COEF_B) ^ mul(a3, COEF_D);
  assign r2 = mul(a0, COEF_D) ^ mul(a1, COEF_9) ^ mul(a2, COEF_E) ^ mul(a3, COEF_B);
  assign r3 = mul(a0, COEF_B) ^ mul(a1, COEF_D) ^ mul(a2, COEF_9) ^ mul(a3, COEF_E);

  assign mixed = {r0, r1, r2, r3};

endmodule

// File: rtl/inv_mixcol_sequencer.sv
// AddRoundKey + InvMixColumns stage with valid/ready handshakes on both sides.
// Default build: one shared column mixer, one column per cycle.
// Define INV_MIXCOL_PARALLEL_EN for four mixers and a single-cycle MIX state.
module inv_mixcol_sequencer
  import aes_dec_pkg::*;
#(
  parameter int unsigned NUM_COLS = 4,
  parameter int unsigned OUT_HOLD = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic [STATE_W-1:0] in_key,
  input  logic               in_skip_mix,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy
);

  fsm_t state;

  // Packed column views: index 3 holds column 0 (the MSB word).
  logic [NUM_COLS-1:0][COL_W-1:0] st_reg;
  logic [NUM_COLS-1:0][COL_W-1:0] res;

  assign out_state = res;
  assign busy      = (state != IDLE);
  // Reset forces IDLE asynchronously, so gate with rst to keep in_ready low.
  assign in_ready  = (state == IDLE) && !rst;

`ifdef INV_MIXCOL_PARALLEL_EN
  col_t mix_par [NUM_COLS];

  for (genvar g = 0; g < NUM_COLS; g++) begin : g_mix
    inv_mix_word u_mix (
      .col   (st_reg[g]),
      .mixed (mix_par[g])
    );
  end
`else
  logic [1:0] col_cnt;
  col_t       mix_in;
  col_t       mix_out;

  assign mix_in = st_reg[2'd3 - col_cnt];

  inv_mix_word u_mix (
    .col   (mix_in),
    .mixed (mix_out)
  );
`endif

  // Sequencer FSM: accept, mix columns, hold result until downstream takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      st_reg    <= '0;
      res       <= '0;
      out_valid <= 1'b0;
`ifndef INV_MIXCOL_PARALLEL_EN
      col_cnt   <= 2'd0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            st_reg  <= in_state ^ in_key;
`ifndef INV_MIXCOL_PARALLEL_EN
            col_cnt <= 2'd0;
`endif
            if (in_skip_mix) begin
              res   <= in_state ^ in_key;
              state <= DONE;
            end else begin
              state <= MIX;
            end
          end
        end
        MIX: begin
`ifdef INV_MIXCOL_PARALLEL_EN
          for (int g = 0; g < NUM_COLS; g++) begin
            res[g] <= mix_par[g];
          end
          state     <= DONE;
          out_valid <= 1'b1;
`else
          res[2'd3 - col_cnt] <= mix_out;
          if (col_cnt == 2'd3) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            col_cnt <= col_cnt + 2'd1;
          end
`endif
        end
        DONE: begin
          // Skip path arrives with out_valid low; it rises one cycle later.
          if (out_valid && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            if (OUT_HOLD == 0) res <= '0;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mixcol_sequencer.sv
// Self-checking bench for inv_mixcol_sequencer against a GF(2^8) reference model.
module tb_inv_mixcol_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [127:0] in_key;
  logic         in_skip_mix;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int checks   = 0;
  int failures = 0;

`ifdef INV_MIXCOL_PARALLEL_EN
  localparam int MIX_LAT = 1;
`else
  localparam int MIX_LAT = 4;
`endif

  localparam logic [127:0] VEC_IN  = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
  localparam logic [127:0] VEC_OUT = 128'hdb135345f20a225c01010101c6c6c6c6;

  always #5 clk = ~clk;

  inv_mixcol_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_state    (in_state),
    .in_key      (in_key),
    .in_skip_mix (in_skip_mix),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_state   (out_state),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // GF(2^8) multiply by shift-and-add, reduction polynomial 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_out(input logic [127:0] s, input logic [127:0] k,
                                           input bit skip);
    logic [127:0] x;
    logic [127:0] r;
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    x = s ^ k;
    if (skip) return x;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gmul(coef[(j - i + 4) % 4], x[127 - 32*c - 8*j -: 8]);
        end
        r[127 - 32*c - 8*i -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic run_txn(input string tag, input logic [127:0] s, input logic [127:0] k,
                         input bit skip, input logic [127:0] exp, input int hold);
    int waitc;
    int lat;
    waitc = 0;
    while (!in_ready && waitc < 10) begin
      tick();
      waitc++;
    end
    check({tag, " in_ready before"}, in_ready, 1);
    in_valid    = 1'b1;
    in_state    = s;
    in_key      = k;
    in_skip_mix = skip;
    tick();
    // Scramble inputs after the accepting edge; they must be ignored.
    in_valid    = 1'b0;
    in_state    = {$urandom, $urandom, $urandom, $urandom};
    in_key      = {$urandom, $urandom, $urandom, $urandom};
    in_skip_mix = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, skip ? 1 : MIX_LAT);
    check({tag, " data"}, out_state, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold valid"}, out_valid, 1);
      check({tag, " hold data"}, out_state, exp);
      check({tag, " hold in_ready"}, in_ready, 0);
      check({tag, " hold busy"}, busy, 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " valid drop"}, out_valid, 0);
    check({tag, " in_ready back"}, in_ready, 1);
    check({tag, " busy drop"}, busy, 0);
    check({tag, " data held"}, out_state, exp);
  endtask

  initial begin
    logic [127:0] k;
    logic [127:0] s;
    bit           sk;
    int           seen;

    rst         = 1'b1;
    in_valid    = 1'b0;
    in_state    = '0;
    in_key      = '0;
    in_skip_mix = 1'b0;
    out_ready   = 1'b0;
    tick();
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_state", out_state, 0);
    check("reset busy", busy, 0);
    rst = 1'b0;
    #1;
    check("post reset in_ready", in_ready, 1);

    run_txn("vec mix", VEC_IN, 128'h0, 1'b0, VEC_OUT, 0);
    run_txn("key only", 128'h1, {128{1'b1}}, 1'b1, {{127{1'b1}}, 1'b0}, 0);
    k = {$urandom, $urandom, $urandom, $urandom};
    run_txn("key then mix", VEC_IN ^ k, k, 1'b0, VEC_OUT, 0);
    run_txn("backpressure", VEC_IN, 128'h0, 1'b0, VEC_OUT, 5);

    // Reset in the middle of a mix: nothing may be emitted afterwards.
    in_valid    = 1'b1;
    in_state    = VEC_IN;
    in_key      = 128'h0;
    in_skip_mix = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst out_state", out_state, 0);
    check("midrst busy", busy, 0);
    check("midrst in_ready", in_ready, 0);
    tick();
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("midrst no emit", seen, 0);
    run_txn("after rst", VEC_IN, 128'h0, 1'b0, VEC_OUT, 0);

    for (int n = 0; n < 25; n++) begin
      s  = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      sk = ($urandom_range(0, 3) == 0);
      run_txn($sformatf("rand%0d", n), s, k, sk, ref_out(s, k, sk), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
